// File: rtl/inert_pkg.sv
// rtl/inert_pkg.sv - states, IMU command words and command lookup for inert_sensor_reader
package inert_pkg;

  typedef enum logic [3:0] {
    WAIT_RST, INIT1, INIT2, INIT3, INIT4, IDLE, RD_PL, RD_PH, RD_AL, RD_AH
  } state_t;

  localparam logic [15:0] CMD_INIT1 = 16'h0D02;
  localparam logic [15:0] CMD_INIT2 = 16'h1053;
  localparam logic [15:0] CMD_INIT3 = 16'h1150;
  localparam logic [15:0] CMD_INIT4 = 16'h1460;
  localparam logic [15:0] CMD_RD_PL = 16'hA200;
  localparam logic [15:0] CMD_RD_PH = 16'hA300;
  localparam logic [15:0] CMD_RD_AL = 16'hAC00;
  localparam logic [15:0] CMD_RD_AH = 16'hAD00;

  // Every state except WAIT_RST and IDLE issues exactly one SPI transaction.
  function automatic logic is_cmd_state(input state_t s);
    return !(s == WAIT_RST || s == IDLE);
  endfunction

  function automatic logic [15:0] state_cmd(input state_t s);
    case (s)
      INIT1:   return CMD_INIT1;
      INIT2:   return CMD_INIT2;
      INIT3:   return CMD_INIT3;
      INIT4:   return CMD_INIT4;
      RD_PL:   return CMD_RD_PL;
      RD_PH:   return CMD_RD_PH;
      RD_AL:   return CMD_RD_AL;
      RD_AH:   return CMD_RD_AH;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous level
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/inert_sensor_reader.sv
// rtl/inert_sensor_reader.sv - IMU init and pitch-rate / Z-accel readout over an SPI master handshake
module inert_sensor_reader
  import inert_pkg::*;
#(
  parameter logic [15:0] INIT_WAIT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic        vld,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ
);

  state_t      state, nxt;
  logic [15:0] timer;
  logic [7:0]  pl, ph, al;
  logic        int_s;
  logic        enter_cmd;
  logic        unused_rd_hi;

  assign unused_rd_hi = ^rd_data[15:8];

  sync_2ff u_int_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (INT),
    .q     (int_s)
  );

  always_comb begin
    nxt = state;
    case (state)
      WAIT_RST: if (timer == INIT_WAIT - 16'd1) nxt = INIT1;
      INIT1:    if (done) nxt = INIT2;
      INIT2:    if (done) nxt = INIT3;
      INIT3:    if (done) nxt = INIT4;
      INIT4:    if (done) nxt = IDLE;
      IDLE:     if (int_s) nxt = RD_PL;
      RD_PL:    if (done) nxt = RD_PH;
      RD_PH:    if (done) nxt = RD_AL;
      RD_AL:    if (done) nxt = RD_AH;
      RD_AH:    if (done) nxt = int_s ? RD_PL : IDLE;
      default:  nxt = WAIT_RST;
    endcase
  end

  // A state change into a command state is the only thing that launches a transaction,
  // so waiting in a state can never re-pulse wrt (RD_AH -> RD_PL is still a change).
  assign enter_cmd = (nxt != state) && is_cmd_state(nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WAIT_RST;
      timer   <= 16'h0000;
      wrt     <= 1'b0;
      cmd     <= 16'h0000;
      vld     <= 1'b0;
      ptch_rt <= 16'h0000;
      AZ      <= 16'h0000;
      pl      <= 8'h00;
      ph      <= 8'h00;
      al      <= 8'h00;
    end else begin
      state <= nxt;
      wrt   <= enter_cmd;
      vld   <= 1'b0;
      if (state == WAIT_RST && timer != 16'hFFFF)
        timer <= timer + 16'd1;
      if (enter_cmd)
        cmd <= state_cmd(nxt);
      if (done) begin
        case (state)
          RD_PL: pl <= rd_data[7:0];
          RD_PH: ph <= rd_data[7:0];
          RD_AL: al <= rd_data[7:0];
          // AH is used straight off the bus so outputs and vld land on the same edge.
          RD_AH: begin
            ptch_rt <= {ph, pl};
            AZ      <= {rd_data[7:0], al};
            vld     <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inert_sensor_reader.sv
// tb/tb_inert_sensor_reader.sv - self-checking bench with SPI master model and scoreboard
module tb_inert_sensor_reader;

  logic        clk;
  logic        rst_n;
  logic        INT;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic        vld;
  logic [15:0] ptch_rt;
  logic [15:0] AZ;

  logic        model_done;
  logic        spur_done;
  logic        busy;
  int          cnt;
  logic [15:0] cur_cmd;
  logic [7:0]  pl_b, ph_b, al_b, ah_b;

  logic [15:0] exp_cmd[$];
  logic [31:0] exp_dat[$];
  int          errors;
  int          checks;
  int          wrt_cnt;

  assign done = model_done | spur_done;

  inert_sensor_reader #(.INIT_WAIT(16'd8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .INT     (INT),
    .done    (done),
    .rd_data (rd_data),
    .wrt     (wrt),
    .cmd     (cmd),
    .vld     (vld),
    .ptch_rt (ptch_rt),
    .AZ      (AZ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] resp(input logic [15:0] c);
    case (c[15:8])
      8'hA2:   return pl_b;
      8'hA3:   return ph_b;
      8'hAC:   return al_b;
      8'hAD:   return ah_b;
      default: return 8'h00;
    endcase
  endfunction

  // One clock: SPI model answers 5 clks after wrt, then the scoreboard inspects outputs.
  task automatic step();
    @(posedge clk);
    #1;
    model_done = 1'b0;
    if (!rst_n) begin
      busy = 1'b0;
    end else if (wrt === 1'b1) begin
      checks++;
      if (busy) begin
        errors++;
        $display("FAIL wrt_while_busy: wrt=1 cmd=%h, required no wrt before done", cmd);
      end
      busy = 1'b1;
      cnt = 5;
      cur_cmd = cmd;
    end else if (busy) begin
      cnt--;
      if (cnt == 0) begin
        model_done = 1'b1;
        rd_data = {8'hEE, resp(cur_cmd)};
        busy = 1'b0;
      end
    end
    #1;
    if (wrt === 1'b1) begin
      wrt_cnt++;
      checks++;
      if (exp_cmd.size() == 0) begin
        errors++;
        $display("FAIL unexpected_wrt: got cmd=%h, required no wrt", cmd);
      end else begin
        logic [15:0] e;
        e = exp_cmd.pop_front();
        if (cmd !== e) begin
          errors++;
          $display("FAIL cmd: got %h, required %h", cmd, e);
        end
      end
    end
    if (vld === 1'b1) begin
      checks++;
      if (exp_dat.size() == 0) begin
        errors++;
        $display("FAIL unexpected_vld: got ptch_rt=%h AZ=%h, required no vld", ptch_rt, AZ);
      end else begin
        logic [31:0] d;
        d = exp_dat.pop_front();
        if ({ptch_rt, AZ} !== d) begin
          errors++;
          $display("FAIL vld_data: got ptch_rt=%h AZ=%h, required %h %h", ptch_rt, AZ, d[31:16], d[15:0]);
        end
      end
    end
  endtask

  task automatic push_init();
    exp_cmd.push_back(16'h0D02);
    exp_cmd.push_back(16'h1053);
    exp_cmd.push_back(16'h1150);
    exp_cmd.push_back(16'h1460);
  endtask

  task automatic push_read(input logic [7:0] pl, input logic [7:0] ph,
                           input logic [7:0] al, input logic [7:0] ah);
    exp_cmd.push_back(16'hA200);
    exp_cmd.push_back(16'hA300);
    exp_cmd.push_back(16'hAC00);
    exp_cmd.push_back(16'hAD00);
    exp_dat.push_back({ph, pl, ah, al});
  endtask

  task automatic set_bytes(input logic [7:0] pl, input logic [7:0] ph,
                           input logic [7:0] al, input logic [7:0] ah);
    pl_b = pl; ph_b = ph; al_b = al; ah_b = ah;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    INT = 1'b0;
    repeat (3) step();
    checks += 5;
    if (wrt !== 1'b0)        begin errors++; $display("FAIL reset_wrt: got %b, required 0", wrt); end
    if (cmd !== 16'h0)       begin errors++; $display("FAIL reset_cmd: got %h, required 0000", cmd); end
    if (vld !== 1'b0)        begin errors++; $display("FAIL reset_vld: got %b, required 0", vld); end
    if (ptch_rt !== 16'h0)   begin errors++; $display("FAIL reset_ptch_rt: got %h, required 0000", ptch_rt); end
    if (AZ !== 16'h0)        begin errors++; $display("FAIL reset_AZ: got %h, required 0000", AZ); end
    push_init();
    rst_n = 1'b1;
    begin
      int n;
      n = 0;
      while (wrt !== 1'b1 && n < 100) begin step(); n++; end
      checks++;
      if (n != 8) begin errors++; $display("FAIL init_latency: got %0d clks, required 8", n); end
    end
  endtask

  task automatic test_init();
    for (int i = 0; i < 300; i++) begin
      if (exp_cmd.size() == 0) break;
      step();
    end
    checks++;
    if (exp_cmd.size() != 0) begin errors++; $display("FAIL init_timeout: got %0d pending cmds, required 0", exp_cmd.size()); end
    wrt_cnt = 0;
    repeat (20) step();
    checks++;
    if (wrt_cnt != 0) begin errors++; $display("FAIL idle_after_init: got %0d wrt, required 0", wrt_cnt); end
  endtask

  task automatic test_read();
    int n;
    set_bytes(8'h34, 8'h12, 8'hCD, 8'hAB);
    push_read(8'h34, 8'h12, 8'hCD, 8'hAB);
    INT = 1'b1;
    n = 0;
    while (wrt !== 1'b1 && n < 50) begin step(); n++; end
    checks++;
    if (n != 3) begin errors++; $display("FAIL int_latency: got %0d clks, required 3", n); end
    INT = 1'b0;
    n = 0;
    while (vld !== 1'b1 && n < 300) begin step(); n++; end
    checks++;
    if (vld !== 1'b1) begin errors++; $display("FAIL read_timeout: got no vld, required vld"); end
    step();
    checks += 2;
    if (vld !== 1'b0) begin errors++; $display("FAIL vld_pulse: got %b, required 0", vld); end
    if (ptch_rt !== 16'h1234 || AZ !== 16'hABCD) begin
      errors++; $display("FAIL read_hold: got %h %h, required 1234 abcd", ptch_rt, AZ);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    set_bytes(8'h11, 8'h22, 8'h33, 8'h44);
    push_read(8'h11, 8'h22, 8'h33, 8'h44);
    push_read(8'h55, 8'h66, 8'h77, 8'h88);
    INT = 1'b1;
    n = 0;
    while (vld !== 1'b1 && n < 300) begin step(); n++; end
    checks++;
    if (wrt !== 1'b1 || cmd !== 16'hA200) begin
      errors++; $display("FAIL back_to_back: got wrt=%b cmd=%h at vld, required 1 a200", wrt, cmd);
    end
    set_bytes(8'h55, 8'h66, 8'h77, 8'h88);
    INT = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (exp_dat.size() == 0 && exp_cmd.size() == 0) break;
      step();
    end
    checks++;
    if (exp_dat.size() != 0) begin errors++; $display("FAIL b2b_timeout: got %0d pending sets, required 0", exp_dat.size()); end
    repeat (5) step();
  endtask

  task automatic test_spurious();
    wrt_cnt = 0;
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    repeat (10) step();
    checks++;
    if (wrt_cnt != 0) begin errors++; $display("FAIL spurious_done: got %0d wrt, required 0", wrt_cnt); end
    set_bytes(8'h9A, 8'h78, 8'h21, 8'h43);
    push_read(8'h9A, 8'h78, 8'h21, 8'h43);
    INT = 1'b1;
    repeat (3) step();
    INT = 1'b0;
    repeat (8) step();
    INT = 1'b1;
    repeat (2) step();
    INT = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (exp_dat.size() == 0) break;
      step();
    end
    wrt_cnt = 0;
    repeat (25) step();
    checks += 2;
    if (exp_dat.size() != 0) begin errors++; $display("FAIL spurious_timeout: got %0d pending sets, required 0", exp_dat.size()); end
    if (wrt_cnt != 0) begin errors++; $display("FAIL int_not_queued: got %0d wrt, required 0", wrt_cnt); end
  endtask

  task automatic test_negative();
    int n;
    set_bytes(8'h80, 8'hFF, 8'h01, 8'h80);
    push_read(8'h80, 8'hFF, 8'h01, 8'h80);
    INT = 1'b1;
    repeat (3) step();
    INT = 1'b0;
    n = 0;
    while (vld !== 1'b1 && n < 300) begin step(); n++; end
    checks++;
    if ($signed(ptch_rt) != -16'sd128) begin
      errors++; $display("FAIL negative_rate: got %0d, required -128", $signed(ptch_rt));
    end
    repeat (5) step();
  endtask

  task automatic test_reset_mid();
    set_bytes(8'h01, 8'h02, 8'h03, 8'h04);
    exp_cmd.push_back(16'hA200);
    exp_cmd.push_back(16'hA300);
    INT = 1'b1;
    repeat (3) step();
    INT = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (exp_cmd.size() == 0) break;
      step();
    end
    repeat (2) step();
    #1 rst_n = 1'b0;
    #1;
    checks += 3;
    if (wrt !== 1'b0 || vld !== 1'b0) begin errors++; $display("FAIL mid_reset_strobes: got wrt=%b vld=%b, required 0 0", wrt, vld); end
    if (cmd !== 16'h0) begin errors++; $display("FAIL mid_reset_cmd: got %h, required 0000", cmd); end
    if (ptch_rt !== 16'h0 || AZ !== 16'h0) begin
      errors++; $display("FAIL mid_reset_data: got %h %h, required 0000 0000", ptch_rt, AZ);
    end
    repeat (3) step();
    push_init();
    rst_n = 1'b1;
    begin
      int n;
      n = 0;
      while (wrt !== 1'b1 && n < 100) begin step(); n++; end
      checks += 2;
      if (n != 8) begin errors++; $display("FAIL reinit_latency: got %0d clks, required 8", n); end
      if (cmd !== 16'h0D02) begin errors++; $display("FAIL reinit_cmd: got %h, required 0d02", cmd); end
    end
    test_init();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    wrt_cnt = 0;
    model_done = 1'b0;
    spur_done = 1'b0;
    busy = 1'b0;
    cnt = 0;
    cur_cmd = 16'h0;
    rd_data = 16'h0;
    set_bytes(8'h00, 8'h00, 8'h00, 8'h00);
    test_reset();
    test_init();
    test_read();
    test_back_to_back();
    test_spurious();
    test_negative();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
